accum_phy_wrapper: RTL and testbench

- Physical accumulator memory stage directly downstream of the accumulator bus.
- Takes one arbitrated write command with data (port A) and one read command (port B) per cycle.
- Performs plain writes or read-modify-write accumulation per SIMD bank into banked storage.
- Returns read data with fixed 1-cycle latency.
- Owns rd_ready: it drops rd_ready whenever an accumulate needs the internal read port.

---
 rtl/accum_phy_wrapper.sv | 124 ++++++++++++
 tb/tb_accum_phy_wrapper.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/accum_phy_wrapper.sv
// Banked accumulator memory stage: plain or read-modify-write per SIMD bank, with one shared read port
// and a one-cycle registered read response.
module accum_phy_wrapper #(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int ZONE_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid,
    input  logic                            accum_en,
    input  logic [NUM_BANKS-1:0]            wr_mask,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [ZONE_WIDTH-1:0]           wr_zone_id,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
    input  logic                            rd_valid,
    input  logic [NUM_BANKS-1:0]            rd_mask,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    input  logic [ZONE_WIDTH-1:0]           rd_zone_id,
    output logic                            rd_ready,
    output logic                            rvalid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] rdata
);
    localparam int IDX_WIDTH = ZONE_WIDTH + ADDR_WIDTH;
    localparam int DEPTH     = 1 << IDX_WIDTH;

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

    logic                  accum_req;
    logic                  rd_accept;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [IDX_WIDTH-1:0]  port_idx;
    logic [DATA_WIDTH-1:0] port_data [NUM_BANKS];

    logic                            s1_valid;
    logic                            s1_accum;
    logic [NUM_BANKS-1:0]            s1_mask;
    logic [IDX_WIDTH-1:0]            s1_idx;
    logic [NUM_BANKS*DATA_WIDTH-1:0] s1_wdata;
    logic [DATA_WIDTH-1:0]           old_q [NUM_BANKS];

    logic                            wb_valid;
    logic [NUM_BANKS-1:0]            wb_mask;
    logic [IDX_WIDTH-1:0]            wb_idx;
    logic [NUM_BANKS*DATA_WIDTH-1:0] wb_data;

    logic                            commit;
    logic [DATA_WIDTH-1:0]           old_word [NUM_BANKS];
    logic [NUM_BANKS*DATA_WIDTH-1:0] new_data;

    assign wr_idx    = {wr_zone_id, wr_addr};
    assign rd_idx    = {rd_zone_id, rd_addr};
    assign accum_req = wr_valid && accum_en;
    assign rd_ready  = !accum_req;
    assign rd_accept = rd_valid && rd_ready;
    assign port_idx  = accum_req ? wr_idx : rd_idx;
    assign commit    = s1_valid && !rst;

    // Single read port, shared between accumulate fetches and external reads; read-first against commits.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            port_data[b] = mem[b][port_idx];
        end
    end

    // The internal read missed last cycle's commit, so the write-back register supplies it instead.
    always_comb begin
        new_data = s1_wdata;
        for (int b = 0; b < NUM_BANKS; b++) begin
            old_word[b] = (wb_valid && (wb_idx == s1_idx) && wb_mask[b])
                        ? wb_data[b*DATA_WIDTH +: DATA_WIDTH] : old_q[b];
            if (s1_accum) begin
                new_data[b*DATA_WIDTH +: DATA_WIDTH] = old_word[b] + s1_wdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (s1_mask[b]) begin
                    mem[b][s1_idx] <= new_data[b*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            wb_valid <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
        end else begin
            s1_valid <= wr_valid;
            wb_valid <= s1_valid;
            rvalid   <= rd_accept;
            if (rd_accept) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    rdata[b*DATA_WIDTH +: DATA_WIDTH] <= rd_mask[b] ? port_data[b] : '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_valid) begin
            s1_accum <= accum_en;
            s1_mask  <= wr_mask;
            s1_idx   <= wr_idx;
            s1_wdata <= wdata;
        end
        if (accum_req) begin
            old_q <= port_data;
        end
        if (s1_valid) begin
            wb_mask <= s1_mask;
            wb_idx  <= s1_idx;
            wb_data <= new_data;
        end
    end
endmodule

// File: tb/tb_accum_phy_wrapper.sv
// Directed-vector bench for accum_phy_wrapper: plain writes, accumulate chains, masking, wrap,
// read stalls, read-first ordering and reset dropping an in-flight write.
module tb_accum_phy_wrapper;
    localparam int NB = 4;
    localparam int DW = 64;
    localparam int AW = 9;
    localparam int ZW = 2;
    localparam int VW = NB * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          accum_en;
    logic [NB-1:0] wr_mask;
    logic [AW-1:0] wr_addr;
    logic [ZW-1:0] wr_zone_id;
    logic [VW-1:0] wdata;
    logic          rd_valid;
    logic [NB-1:0] rd_mask;
    logic [AW-1:0] rd_addr;
    logic [ZW-1:0] rd_zone_id;
    logic          rd_ready;
    logic          rvalid;
    logic [VW-1:0] rdata;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    accum_phy_wrapper #(
        .NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZONE_WIDTH(ZW)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .accum_en(accum_en), .wr_mask(wr_mask),
        .wr_addr(wr_addr), .wr_zone_id(wr_zone_id), .wdata(wdata),
        .rd_valid(rd_valid), .rd_mask(rd_mask), .rd_addr(rd_addr), .rd_zone_id(rd_zone_id),
        .rd_ready(rd_ready), .rvalid(rvalid), .rdata(rdata)
    );

    function automatic logic [VW-1:0] rep(input logic [DW-1:0] w);
        return {NB{w}};
    endfunction

    task automatic checkOutput(input string tag, input logic [VW-1:0] observed, input logic [VW-1:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic acc, input logic [NB-1:0] wm,
                                 input logic [ZW-1:0] wz, input logic [AW-1:0] wa, input logic [VW-1:0] wd,
                                 input logic rv, input logic [NB-1:0] rm,
                                 input logic [ZW-1:0] rz, input logic [AW-1:0] ra);
        wr_valid   = wv;
        accum_en   = acc;
        wr_mask    = wm;
        wr_zone_id = wz;
        wr_addr    = wa;
        wdata      = wd;
        rd_valid   = rv;
        rd_mask    = rm;
        rd_zone_id = rz;
        rd_addr    = ra;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
        step();
    endtask

    task automatic writeCycle(input logic acc, input logic [NB-1:0] wm, input logic [ZW-1:0] wz,
                              input logic [AW-1:0] wa, input logic [VW-1:0] wd);
        applyStimulus(1'b1, acc, wm, wz, wa, wd, 1'b0, '0, '0, '0);
        #1;
        checkOutput(acc ? "rd_ready_low_on_accum" : "rd_ready_high_on_write", VW'(rd_ready), VW'(!acc));
        step();
    endtask

    task automatic readCycle(input string tag, input logic [NB-1:0] rm, input logic [ZW-1:0] rz,
                             input logic [AW-1:0] ra, input logic [VW-1:0] expected);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, rm, rz, ra);
        step();
        checkOutput({tag, "_rvalid"}, VW'(rvalid), VW'(1'b1));
        checkOutput({tag, "_rdata"}, rdata, expected);
    endtask

    initial begin
        rst = 1'b1;
        idleCycle();
        idleCycle();
        checkOutput("reset_rvalid", VW'(rvalid), '0);
        checkOutput("reset_rdata", rdata, '0);
        checkOutput("reset_rd_ready", VW'(rd_ready), VW'(1'b1));
        rst = 1'b0;
        idleCycle();

        writeCycle(1'b0, 4'b1111, 2'd0, 9'd5, rep(64'h10));
        idleCycle();
        readCycle("plain_write", 4'b1111, 2'd0, 9'd5, rep(64'h10));
        idleCycle();
        checkOutput("rvalid_drops", VW'(rvalid), '0);
        checkOutput("rdata_holds", rdata, rep(64'h10));

        writeCycle(1'b0, 4'b0000, 2'd0, 9'd5, rep(64'h99));
        idleCycle();
        readCycle("mask0_noop", 4'b1111, 2'd0, 9'd5, rep(64'h10));

        writeCycle(1'b0, 4'b1111, 2'd1, 9'd3, rep(64'h10));
        writeCycle(1'b1, 4'b1111, 2'd1, 9'd3, rep(64'h1));
        writeCycle(1'b1, 4'b1111, 2'd1, 9'd3, rep(64'h2));
        writeCycle(1'b1, 4'b1111, 2'd1, 9'd3, rep(64'h3));
        idleCycle();
        readCycle("accum_chain", 4'b1111, 2'd1, 9'd3, rep(64'h16));

        writeCycle(1'b0, 4'b1111, 2'd2, 9'h1F, rep(64'h10));
        idleCycle();
        writeCycle(1'b1, 4'b0101, 2'd2, 9'h1F, rep(64'h5));
        idleCycle();
        readCycle("masked_accum_full", 4'b1111, 2'd2, 9'h1F, {64'h10, 64'h15, 64'h10, 64'h15});
        readCycle("masked_accum_part", 4'b0011, 2'd2, 9'h1F, {64'h0, 64'h0, 64'h10, 64'h15});

        writeCycle(1'b0, 4'b1111, 2'd3, 9'h1FF, rep(64'hFFFF_FFFF_FFFF_FFFF));
        readCycle("pre_stall_read", 4'b1111, 2'd0, 9'd5, rep(64'h10));
        applyStimulus(1'b1, 1'b1, 4'b1111, 2'd3, 9'h1FF, rep(64'h2), 1'b1, 4'b1111, 2'd1, 9'd3);
        #1;
        checkOutput("stall_rd_ready", VW'(rd_ready), '0);
        step();
        checkOutput("stall_no_rvalid", VW'(rvalid), '0);
        checkOutput("stall_rdata_holds", rdata, rep(64'h10));
        idleCycle();
        readCycle("wrap_max_index", 4'b1111, 2'd3, 9'h1FF, rep(64'h1));

        writeCycle(1'b0, 4'b1111, 2'd0, 9'd7, rep(64'h11));
        idleCycle();
        writeCycle(1'b0, 4'b1111, 2'd0, 9'd7, rep(64'hAA));
        readCycle("read_first_old", 4'b1111, 2'd0, 9'd7, rep(64'h11));
        readCycle("read_first_new", 4'b1111, 2'd0, 9'd7, rep(64'hAA));

        readCycle("pre_reset_read", 4'b1111, 2'd0, 9'd5, rep(64'h10));
        writeCycle(1'b1, 4'b1111, 2'd1, 9'd3, rep(64'h100));
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 4'b1111, 2'd0, 9'd5);
        step();
        checkOutput("midreset_rvalid", VW'(rvalid), '0);
        checkOutput("midreset_rdata", rdata, '0);
        rst = 1'b0;
        idleCycle();
        checkOutput("postreset_rvalid", VW'(rvalid), '0);
        readCycle("reset_dropped_write", 4'b1111, 2'd1, 9'd3, rep(64'h16));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
